// File: rtl/std_skid_buffer_pkg.sv
// Shared definitions for the two-entry skid buffer: state encoding and
// the occupancy decode used by the block and its bench.
package std_skid_buffer_pkg;

  // Occupancy states; 2'b10 is unused and recovers to SKID_EMPTY.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_BUSY  = 2'b01,
    SKID_FULL  = 2'b11
  } skid_state_e;

  // Number of entries held for a given state encoding.
  function automatic logic [1:0] skid_count(input logic [1:0] state);
    logic [1:0] cnt;
    case (state)
      SKID_BUSY: cnt = 2'd1;
      SKID_FULL: cnt = 2'd2;
      default:   cnt = 2'd0;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/std_dffern.sv
// D flip-flop bank with load enable and synchronous active-low reset.
module std_dffern #(
  parameter int                WIDTH       = 1,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset to RESET_VALUE, otherwise load d only when enabled.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/std_skid_buffer.sv
// Two-entry valid/ready register slice. The main entry drives the
// downstream port; the skid entry catches the beat accepted while the
// downstream stalls, so s_ready never depends combinationally on m_ready.
module std_skid_buffer
  import std_skid_buffer_pkg::*;
#(
  parameter int                    DATA_WIDTH       = 32,
  parameter logic [DATA_WIDTH-1:0] DATA_RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            count
);

  logic [1:0]            state_q;
  logic [1:0]            state_d;
  logic                  s_fire;
  logic                  m_fire;
  logic                  main_en;
  logic                  skid_en;
  logic [DATA_WIDTH-1:0] main_d;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] skid_q;

  // Handshake outputs are pure decodes of the registered state.
  assign m_valid = (state_q != SKID_EMPTY);
  assign s_ready = (state_q != SKID_FULL);
  assign count   = skid_count(state_q);
  assign m_data  = main_q;

  assign s_fire = s_valid & s_ready;
  assign m_fire = m_valid & m_ready;

  // When draining from FULL the main entry refills from the older skid entry.
  assign main_d = (state_q == SKID_FULL) ? skid_q : s_data;

  // Next-state and data-register enables; flush empties without loading.
  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    if (flush) begin
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (s_fire) begin
            main_en = 1'b1;
            state_d = SKID_BUSY;
          end else begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_BUSY: begin
          if (s_fire && m_fire) begin
            main_en = 1'b1;
            state_d = SKID_BUSY;
          end else if (s_fire) begin
            skid_en = 1'b1;
            state_d = SKID_FULL;
          end else if (m_fire) begin
            state_d = SKID_EMPTY;
          end else begin
            state_d = SKID_BUSY;
          end
        end
        SKID_FULL: begin
          if (m_fire) begin
            main_en = 1'b1;
            state_d = SKID_BUSY;
          end else begin
            state_d = SKID_FULL;
          end
        end
        default: begin
          state_d = SKID_EMPTY;
        end
      endcase
    end
  end

  std_dffern #(
    .WIDTH       (2),
    .RESET_VALUE (SKID_EMPTY)
  ) u_state (
    .clk    (clk),
    .resetn (resetn),
    .en     (1'b1),
    .d      (state_d),
    .q      (state_q)
  );

  std_dffern #(
    .WIDTH       (DATA_WIDTH),
    .RESET_VALUE (DATA_RESET_VALUE)
  ) u_main (
    .clk    (clk),
    .resetn (resetn),
    .en     (main_en),
    .d      (main_d),
    .q      (main_q)
  );

  std_dffern #(
    .WIDTH       (DATA_WIDTH),
    .RESET_VALUE (DATA_RESET_VALUE)
  ) u_skid (
    .clk    (clk),
    .resetn (resetn),
    .en     (skid_en),
    .d      (s_data),
    .q      (skid_q)
  );

endmodule
